// File: rtl/fp32_p8_pipe.sv
// IEEE-754 binary32 to posit<8,0> converter: decode/classify stage then
// regime build, round-to-nearest-even and saturation stage, valid/ready on both sides.
module fp32_p8_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      fp32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       p8,
  output logic             out_sat,
  output logic             out_nar,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clr_count
);

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_NAR  = 3'd1,
    CLS_MAX  = 3'd2,
    CLS_MIN  = 3'd3,
    CLS_NORM = 3'd4
  } cls_t;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [8:0]        r_s1_e;
  logic [22:0]       r_s1_man;
  cls_t              r_s1_cls;

  logic              r_s2_valid;
  logic [7:0]        r_p8;
  logic              r_sat;
  logic              r_nar;
  logic [CNT_W-1:0]  r_sat_count;

  logic              w_s1_adv;
  logic signed [8:0] w_e;
  cls_t              w_cls;

  logic              w_neg;
  logic [8:0]        w_nk;
  logic [8:0]        w_ones;
  logic [8:0]        w_rl;
  logic [31:0]       w_regime;
  logic [31:0]       w_frac;
  logic [31:0]       w_vec;
  logic [6:0]        w_body;
  logic              w_guard;
  logic              w_sticky;
  logic              w_rnd;
  logic [7:0]        w_sum;
  logic [6:0]        w_mag;
  logic              w_use_mag;
  logic              w_sat;
  logic              w_nar;
  logic [7:0]        w_fixed;
  logic [7:0]        w_res;

  assign w_s1_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign out_valid = r_s2_valid;
  assign p8        = r_p8;
  assign out_sat   = r_sat;
  assign out_nar   = r_nar;
  assign sat_count = r_sat_count;

  assign w_e = $signed({1'b0, fp32[30:23]}) - 9'sd127;

  // Stage-1 classification of the incoming operand
  always_comb begin
    w_cls = CLS_NORM;
    if (fp32[30:23] == 8'd0) begin
      w_cls = CLS_ZERO;
    end else if (fp32[30:23] == 8'hFF) begin
      w_cls = CLS_NAR;
    end else if (w_e >= 9'sd6) begin
      w_cls = CLS_MAX;
    end else if (w_e <= -9'sd7) begin
      w_cls = CLS_MIN;
    end else begin
      w_cls = CLS_NORM;
    end
  end

  // Stage-1 register: sign, unbiased exponent, mantissa, class
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_e     <= 9'd0;
      r_s1_man   <= 23'd0;
      r_s1_cls   <= CLS_ZERO;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        r_s1_sign <= fp32[31];
        r_s1_e    <= w_e;
        r_s1_man  <= fp32[22:0];
        r_s1_cls  <= w_cls;
      end
    end
  end

  // Regime and mantissa are MSB-aligned in one word so body/guard/sticky fall at fixed bits
  assign w_neg    = r_s1_e[8];
  assign w_nk     = 9'd0 - r_s1_e;
  assign w_ones   = r_s1_e + 9'd1;
  assign w_rl     = w_neg ? (w_nk + 9'd1) : (r_s1_e + 9'd2);
  assign w_regime = w_neg ? (32'h8000_0000 >> w_nk) : ~(32'hFFFF_FFFF >> w_ones);
  assign w_frac   = {r_s1_man, 9'd0} >> w_rl;
  assign w_vec    = w_regime | w_frac;
  assign w_body   = w_vec[31:25];
  assign w_guard  = w_vec[24];
  assign w_sticky = |w_vec[23:0];
  assign w_rnd    = w_guard && (w_sticky || w_body[0]);
  assign w_sum    = {1'b0, w_body} + {7'd0, w_rnd};

  // Stage-2 result selection, clamping and sign application
  always_comb begin
    w_mag     = 7'h00;
    w_use_mag = 1'b0;
    w_sat     = 1'b0;
    w_nar     = 1'b0;
    w_fixed   = 8'h00;
    case (r_s1_cls)
      CLS_ZERO: begin
        w_fixed = 8'h00;
      end
      CLS_NAR: begin
        w_fixed = 8'h80;
        w_nar   = 1'b1;
      end
      CLS_MAX: begin
        w_mag     = 7'h7F;
        w_use_mag = 1'b1;
        w_sat     = 1'b1;
      end
      CLS_MIN: begin
        w_mag     = 7'h01;
        w_use_mag = 1'b1;
        w_sat     = 1'b1;
      end
      CLS_NORM: begin
        w_use_mag = 1'b1;
        if (w_sum[7]) begin
          w_mag = 7'h7F;
        end else if (w_sum[6:0] == 7'h00) begin
          w_mag = 7'h01;
        end else begin
          w_mag = w_sum[6:0];
        end
      end
      default: begin
        w_fixed = 8'h00;
      end
    endcase
    if (w_use_mag && r_s1_sign) begin
      w_res = 8'd0 - {1'b0, w_mag};
    end else if (w_use_mag) begin
      w_res = {1'b0, w_mag};
    end else begin
      w_res = w_fixed;
    end
  end

  // Stage-2 output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_p8       <= 8'h00;
      r_sat      <= 1'b0;
      r_nar      <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_adv && r_s1_valid) begin
        r_p8  <= w_res;
        r_sat <= w_sat;
        r_nar <= w_nar;
      end
    end
  end

  // Saturating count of clamped results actually delivered; clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_count <= {CNT_W{1'b0}};
    end else if (clr_count) begin
      r_sat_count <= {CNT_W{1'b0}};
    end else if (r_s2_valid && out_ready && r_sat && (r_sat_count != {CNT_W{1'b1}})) begin
      r_sat_count <= r_sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_sat_count <= r_sat_count;
    end
  end

endmodule

// File: tb/tb_fp32_p8_pipe.sv
// Bench for fp32_p8_pipe: real-valued nearest-posit model with a scoreboard,
// directed vectors, backpressure, reset and a full posit8 round trip.
module tb_fp32_p8_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp32 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  p8;
  logic        out_sat;
  logic        out_nar;
  logic [15:0] sat_count;
  logic        clr_count = 1'b0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [9:0]  sbq[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [9:0]  sb_e;
  logic [9:0]  prev_out;
  bit          prev_stall = 1'b0;
  bit          xfer;

  fp32_p8_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp32(fp32), .out_valid(out_valid), .out_ready(out_ready), .p8(p8),
    .out_sat(out_sat), .out_nar(out_nar), .sat_count(sat_count), .clr_count(clr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // posit<8,0> magnitude field -> regime k, fraction bit count and fraction bits
  function automatic void pdecode(input logic [6:0] b, output int k, output int nf, output int fb);
    int  m;
    logic r;
    r = b[6];
    m = 0;
    for (int i = 6; i >= 0; i--) begin
      if (b[i] != r) break;
      m++;
    end
    k  = r ? m - 1 : -m;
    nf = (m >= 6) ? 0 : 6 - m;
    fb = 0;
    for (int i = nf - 1; i >= 0; i--) fb = fb * 2 + int'(b[i]);
  endfunction

  function automatic real pval(input logic [6:0] b);
    int k, nf, fb;
    pdecode(b, k, nf, fb);
    return (1.0 + real'(fb) / (2.0 ** nf)) * (2.0 ** k);
  endfunction

  // Expected {nar, sat, p8}: nearest positive posit by value, ties to the even code
  function automatic logic [9:0] model(input logic [31:0] f);
    int         ex;
    int         e;
    int         best;
    logic [6:0] mag;
    logic       sat;
    logic [7:0] res;
    real        x, d, bd;
    ex  = int'(f[30:23]);
    e   = ex - 127;
    sat = 1'b0;
    mag = 7'h00;
    if (ex == 0) return 10'h000;
    if (ex == 255) return 10'h280;
    if (e >= 6) begin
      mag = 7'h7F; sat = 1'b1;
    end else if (e <= -7) begin
      mag = 7'h01; sat = 1'b1;
    end else begin
      x    = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** e);
      best = 1;
      bd   = 1.0e30;
      for (int c = 1; c < 128; c++) begin
        d = x - pval(7'(c));
        if (d < 0.0) d = -d;
        if (d < bd || (d == bd && (c % 2) == 0)) begin
          bd = d; best = c;
        end
      end
      mag = 7'(best);
    end
    res = f[31] ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    return {1'b0, sat, res};
  endfunction

  // posit8 code -> exact binary32 encoding of its value
  function automatic logic [31:0] p8_to_fp32(input logic [7:0] c);
    int         k, nf, fb;
    logic [7:0] mag;
    logic [22:0] man;
    if (c == 8'h00) return 32'd0;
    mag = c[7] ? (8'd0 - c) : c;
    pdecode(mag[6:0], k, nf, fb);
    man = 23'(fb) << (23 - nf);
    return {c[7], 8'(k + 127), man};
  endfunction

  // Scoreboard: accepts feed the queue, output transfers pop and compare
  always @(negedge clk) begin
    if (chk_en) begin
      if (prev_stall && out_valid) check("hold_stable", 32'({out_nar, out_sat, p8}), 32'(prev_out));
      check("sat_count", 32'(sat_count), 32'(exp_cnt));
      xfer = rst_n && out_valid && out_ready;
      sb_e = 10'h000;
      if (xfer) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", p8);
        end else begin
          sb_e = sbq.pop_front();
          check("result", 32'({out_nar, out_sat, p8}), 32'(sb_e));
        end
      end
      if (!rst_n || clr_count) exp_cnt = 16'd0;
      else if (xfer && sb_e[8] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (rst_n && in_valid && in_ready) sbq.push_back(model(fp32));
      if (!rst_n) sbq.delete();
      prev_stall = rst_n && out_valid && !out_ready;
      prev_out   = {out_nar, out_sat, p8};
    end
  end

  task automatic push(input logic [31:0] v, input bit rnd);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; fp32 = v;
    while (!acc && n < 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: got no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
    end
  endtask

  task automatic lat(input logic [31:0] v);
    out_ready = 1'b1;
    push(v, 1'b0);
    @(negedge clk); check("latency_c1", 32'(out_valid), 32'd0);
    @(negedge clk); check("latency_c2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [31:0] vf [16];
  logic [9:0]  ve [16];
  logic [31:0] bp [4];
  logic [9:0]  mres;
  logic [31:0] rt;
  int          acc_n, idx, good, nv;
  bit          a;

  initial begin
    vf = '{32'h3F800000, 32'hBFC00000, 32'h00000000, 32'h80000000,
           32'h3F820000, 32'h3F860000, 32'h3F830000, 32'h42C80000,
           32'hBA83126F, 32'h7FC00000, 32'hFF800000, 32'h3C800000,
           32'hBC800000, 32'h42800000, 32'h42700000, 32'h3C400000};
    ve = '{10'h040, 10'h0B0, 10'h000, 10'h000,
           10'h040, 10'h042, 10'h041, 10'h17F,
           10'h1FF, 10'h280, 10'h280, 10'h001,
           10'h0FF, 10'h17F, 10'h07F, 10'h101};
    bp = '{32'h42C80000, 32'h3F800000, 32'hBA83126F, 32'h3F860000};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_p8", 32'(p8), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_out_nar", 32'(out_nar), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      mres = model(vf[i]);
      check($sformatf("model_vec%0d", i), 32'(mres), 32'(ve[i]));
    end

    for (int i = 0; i < 4; i++) lat(vf[i]);
    out_ready = 1'b1;
    for (int i = 4; i < 16; i++) push(vf[i], 1'b0);
    drain();

    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk); check("clr_before", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    push(32'h42C80000, 1'b0);
    push(32'hBA83126F, 1'b0);
    drain();
    @(negedge clk); check("sat_count_two", 32'(sat_count), 32'd2);
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk); check("clr_after", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(32'h42C80000, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1; clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    @(negedge clk); check("clr_priority", 32'(sat_count), 32'd0);
    @(posedge clk); #1;

    out_ready = 1'b0;
    acc_n = 0; idx = 0;
    in_valid = 1'b1; fp32 = bp[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); a = in_ready;
      @(posedge clk); #1;
      if (a) begin
        acc_n++; idx++;
        if (idx < 4) fp32 = bp[idx];
      end
    end
    check("bp_accepts", 32'(acc_n), 32'd2);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_no_count", 32'(sat_count), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    good = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) good++;
      a = in_valid && in_ready;
      @(posedge clk); #1;
      if (a) begin
        idx++;
        if (idx < 4) fp32 = bp[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("bp_burst", 32'(good), 32'd4);
    drain();
    @(negedge clk); check("bp_sat_count", 32'(sat_count), 32'd2);
    @(posedge clk); #1;

    out_ready = 1'b0;
    push(32'h3F800000, 1'b0);
    push(32'h42C80000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sat_count", 32'(sat_count), 32'd0);
    out_ready = 1'b1;
    nv = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_stale", 32'(nv), 32'd0);
    @(posedge clk); #1;

    for (int c = 0; c < 256; c++) begin
      if (c != 128) begin
        rt   = p8_to_fp32(8'(c));
        mres = model(rt);
        check($sformatf("roundtrip_%02h", c), 32'(mres[7:0]), 32'(c));
        push(rt, 1'b1);
      end
    end
    drain();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
